// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch vs load/store arbiter and access sequencer for the data memory port.
// Optional starvation guard for fetch: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int MEM_BITS      = 20,
  parameter int DATA_SIZE     = 64,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [MEM_BITS-1:0]  if_addr,
  output logic                 if_gnt,
  output logic                 if_rsp_valid,
  output logic [DATA_SIZE-1:0] if_rsp_data,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [MEM_BITS-1:0]  ls_addr,
  input  logic [2:0]           ls_mode,
  input  logic [DATA_SIZE-1:0] ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_rsp_valid,
  output logic [DATA_SIZE-1:0] ls_rsp_data,
  output logic                 mem_we,
  output logic [MEM_BITS-1:0]  mem_addr,
  output logic [2:0]           mem_mode,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [2:0] MODE_LWU = 3'b110;

  state_t               state;
  state_t               state_nx;
  logic                 own_ls;
  logic [MEM_BITS-1:0]  addr_q;
  logic [2:0]           mode_q;
  logic                 we_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [3:0]           cnt_q;
  logic                 last;
  logic                 force_if;

  assign last = (cnt_q == 4'd0);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  assign force_if = (starve_q == 4'(STARVE_LIMIT));

  // count contested decisions lost by fetch; a fetch grant clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else if (if_gnt) begin
      starve_q <= 4'd0;
    end else if (ls_gnt && if_req) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // arbitration, next state and memory port drive
  always_comb begin
    state_nx  = state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_mode  = 3'b000;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (ls_req && !(if_req && force_if)) begin
          ls_gnt   = 1'b1;
          state_nx = BUSY;
        end else if (if_req) begin
          if_gnt   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        mem_addr  = addr_q;
        mem_mode  = mode_q;
        mem_wdata = wdata_q;
        mem_we    = we_q && last;
        if (last) begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  // latch the winning request, run the access counter, register responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_ls       <= 1'b0;
      addr_q       <= '0;
      mode_q       <= 3'b000;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_data  <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if (ls_gnt) begin
        own_ls  <= 1'b1;
        addr_q  <= ls_addr;
        mode_q  <= ls_mode;
        we_q    <= ls_we;
        wdata_q <= ls_wdata;
        cnt_q   <= CNT_LOAD;
      end else if (if_gnt) begin
        own_ls  <= 1'b0;
        addr_q  <= if_addr;
        mode_q  <= MODE_LWU;
        we_q    <= 1'b0;
        wdata_q <= '0;
        cnt_q   <= CNT_LOAD;
      end else if (state == BUSY && !last) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state == BUSY && last) begin
        if (own_ls) begin
          ls_rsp_valid <= 1'b1;
          if (!we_q) begin
            ls_rsp_data <= mem_rdata;
          end
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant timing, responses, stores,
// contention and mid-access reset against a small memory model.
module tb_mem_port_arbiter;

  localparam int MB = 20;
  localparam int DS = 64;
  localparam int AC = 2;
  localparam int SL = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [MB-1:0] if_addr;
  logic          if_gnt;
  logic          if_rsp_valid;
  logic [DS-1:0] if_rsp_data;
  logic          ls_req;
  logic          ls_we;
  logic [MB-1:0] ls_addr;
  logic [2:0]    ls_mode;
  logic [DS-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rsp_valid;
  logic [DS-1:0] ls_rsp_data;
  logic          mem_we;
  logic [MB-1:0] mem_addr;
  logic [2:0]    mem_mode;
  logic [DS-1:0] mem_wdata;
  logic [DS-1:0] mem_rdata;

  logic [DS-1:0] mem [0:255];

  int total;
  int bad;

  int         rsp_k;
  logic [7:0] we_mask;
  logic [2:0] mode1;
  logic [63:0] rdata;
  logic       g_gnt;
  logic       g_ogn;
  logic       oth;

  mem_port_arbiter #(
    .MEM_BITS(MB),
    .DATA_SIZE(DS),
    .ACCESS_CYCLES(AC),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data),
    .ls_req(ls_req),
    .ls_we(ls_we),
    .ls_addr(ls_addr),
    .ls_mode(ls_mode),
    .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt),
    .ls_rsp_valid(ls_rsp_valid),
    .ls_rsp_data(ls_rsp_data),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_mode(mem_mode),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: LD full, LW sign-extended, LWU zero-extended
  always_comb begin
    logic [63:0] w;
    w = mem[mem_addr[7:0]];
    case (mem_mode)
      3'b010:  mem_rdata = {{32{w[31]}}, w[31:0]};
      3'b110:  mem_rdata = {32'h0, w[31:0]};
      default: mem_rdata = w;
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_mode == 3'b010) begin
        mem[mem_addr[7:0]][31:0] <= mem_wdata[31:0];
      end else begin
        mem[mem_addr[7:0]] <= mem_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit fe, input bit we, input logic [MB-1:0] a,
                      input logic [2:0] m, input logic [63:0] d);
    @(negedge clk);
    if (fe) begin
      if_req  = 1'b1;
      if_addr = a;
    end else begin
      ls_req   = 1'b1;
      ls_we    = we;
      ls_addr  = a;
      ls_mode  = m;
      ls_wdata = d;
    end
    #1;
    g_gnt   = fe ? if_gnt : ls_gnt;
    g_ogn   = fe ? ls_gnt : if_gnt;
    rsp_k   = -1;
    we_mask = 8'h0;
    oth     = 1'b0;
    mode1   = 3'b000;
    rdata   = 64'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if_req   = 1'b0;
      ls_req   = 1'b0;
      ls_we    = 1'b0;
      ls_addr  = '0;
      if_addr  = '0;
      ls_mode  = 3'b000;
      ls_wdata = '0;
      #1;
      if (mem_we) we_mask[k] = 1'b1;
      if (k == 1) mode1 = mem_mode;
      if ((fe ? if_rsp_valid : ls_rsp_valid) && rsp_k < 0) begin
        rsp_k = k;
        rdata = fe ? if_rsp_data : ls_rsp_data;
      end
      if (fe ? ls_rsp_valid : if_rsp_valid) oth = 1'b1;
    end
  endtask

  initial begin
    int nls;
    int nif;
    int nodd;
    int first_if;
    int exp_ls;
    int exp_if;
    int exp_first;
    logic seen;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_mode  = 3'b000;
    ls_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[16] = 64'h1122334455667788;
    mem[4]  = 64'hA5A5A5A5_87654321;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_gnt", 64'(if_gnt), 64'h0);
    chk("rst_ls_gnt", 64'(ls_gnt), 64'h0);
    chk("rst_if_rv", 64'(if_rsp_valid), 64'h0);
    chk("rst_ls_rv", 64'(ls_rsp_valid), 64'h0);
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_ls_data", ls_rsp_data, 64'h0);
    chk("rst_if_data", if_rsp_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single load
    xfer(1'b0, 1'b0, 20'h10, 3'b011, 64'h0);
    chk("ld_gnt", 64'(g_gnt), 64'h1);
    chk("ld_if_gnt", 64'(g_ogn), 64'h0);
    chk("ld_rsp_k", 64'(rsp_k), 64'(AC + 1));
    chk("ld_we_mask", 64'(we_mask), 64'h0);
    chk("ld_data", rdata, 64'h1122334455667788);
    chk("ld_if_rsp", 64'(oth), 64'h0);

    // single store
    xfer(1'b0, 1'b1, 20'h20, 3'b010, 64'hDEADBEEF);
    chk("st_gnt", 64'(g_gnt), 64'h1);
    chk("st_we_mask", 64'(we_mask), 64'(1 << AC));
    chk("st_rsp_k", 64'(rsp_k), 64'(AC + 1));
    chk("st_data_hold", ls_rsp_data, 64'h1122334455667788);
    chk("st_mem", mem[32], 64'h00000000DEADBEEF);

    // readback of the store with sign extension
    xfer(1'b0, 1'b0, 20'h20, 3'b010, 64'h0);
    chk("rb_rsp_k", 64'(rsp_k), 64'(AC + 1));
    chk("rb_data", rdata, 64'hFFFFFFFFDEADBEEF);

    // fetch
    xfer(1'b1, 1'b0, 20'h4, 3'b000, 64'h0);
    chk("fe_gnt", 64'(g_gnt), 64'h1);
    chk("fe_ls_gnt", 64'(g_ogn), 64'h0);
    chk("fe_mode", 64'(mode1), 64'h6);
    chk("fe_rsp_k", 64'(rsp_k), 64'(AC + 1));
    chk("fe_data", rdata, 64'h0000000087654321);
    chk("fe_we_mask", 64'(we_mask), 64'h0);
    chk("fe_ls_rsp", 64'(oth), 64'h0);
    chk("fe_ls_data", ls_rsp_data, 64'hFFFFFFFFDEADBEEF);

    // contention with both requests held
    nls      = 0;
    nif      = 0;
    nodd     = 0;
    first_if = -1;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 20'h4;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 20'h10;
    ls_mode = 3'b011;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (ls_gnt) nls++;
      if (if_gnt) begin
        nif++;
        if (first_if < 0) first_if = c;
      end
      if ((ls_gnt || if_gnt) && (c % (AC + 1)) != 0) nodd++;
      @(negedge clk);
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (4) @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_ls    = 8;
    exp_if    = 2;
    exp_first = 12;
`else
    exp_ls    = 10;
    exp_if    = 0;
    exp_first = -1;
`endif
    chk("ct_ls_cnt", 64'(nls), 64'(exp_ls));
    chk("ct_if_cnt", 64'(nif), 64'(exp_if));
    chk("ct_first_if", 64'(first_if), 64'(exp_first));
    chk("ct_spacing", 64'(nodd), 64'h0);

    // reset in the middle of a store
    @(negedge clk);
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 20'h30;
    ls_mode  = 3'b011;
    ls_wdata = 64'h0123456789ABCDEF;
    #1;
    chk("rs_gnt", 64'(ls_gnt), 64'h1);
    @(negedge clk);
    ls_req = 1'b0;
    ls_we  = 1'b0;
    #1;
    chk("rs_busy_addr", 64'(mem_addr), 64'h30);
    rst_n = 1'b0;
    #1;
    chk("rs_mem_addr", 64'(mem_addr), 64'h0);
    chk("rs_mem_wdata", mem_wdata, 64'h0);
    chk("rs_mem_we", 64'(mem_we), 64'h0);
    chk("rs_ls_data", ls_rsp_data, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (ls_rsp_valid || if_rsp_valid || mem_we) seen = 1'b1;
      @(negedge clk);
    end
    chk("rs_no_rsp", 64'(seen), 64'h0);
    chk("rs_mem_30", mem[48], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the shared data memory. It owns the single memory port (address, funct3 mode, write enable, write data, read data) and multiplexes it between the instruction-fetch stage and the load/store stage. Each access is stretched to a configurable number of cycles and answered with a registered one-cycle response pulse. It sits between the pipeline front end and LSU and the 64-bit memory buffer.

## Interface
- MEM_BITS, 20, memory address width (doubleword-indexed)
- DATA_SIZE, 64, data width
- ACCESS_CYCLES, 2, cycles the memory port is held per access; legal range 1..15
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win; legal range 1..15
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  MEM_BITS  fetch address
- if_gnt  out  1  fetch grant (combinational, IDLE only)
- if_rsp_valid  out  1  one-cycle fetch response pulse
- if_rsp_data  out  DATA_SIZE  fetch read data
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  MEM_BITS  load/store address
- ls_mode  in  3  funct3 access mode
- ls_wdata  in  DATA_SIZE  store data
- ls_gnt  out  1  load/store grant (combinational, IDLE only)
- ls_rsp_valid  out  1  one-cycle load/store response pulse; also pulses for stores
- ls_rsp_data  out  DATA_SIZE  load read data
- mem_we  out  1  memory write enable
- mem_addr  out  MEM_BITS  memory address
- mem_mode  out  3  memory funct3 mode
- mem_wdata  out  DATA_SIZE  memory write data
- mem_rdata  in  DATA_SIZE  memory read data (combinational from mem_addr/mem_mode)

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any request is present, pick a winner, assert that grant only, latch owner, address, mode, we, and wdata, load the cycle counter with ACCESS_CYCLES-1, and go to BUSY. With no request, stay in IDLE.
- Fetch accesses always use mode 3'b110 (LWU, 32-bit zero-extended) with we=0.
- Arbitration: fetch only → fetch; LSU only → LSU; both → LSU unless the starvation guard forces fetch (see Configuration).
- BUSY: mem_addr, mem_mode, and mem_wdata are driven from the latched fields. The counter decrements each cycle. mem_we is asserted only in the final BUSY cycle (counter==0) and only for a latched store, so exactly one write occurs per store.
- On the final BUSY cycle edge:
  - For a load or fetch, mem_rdata is captured into the owner's rsp_data register.
  - For a store, ls_rsp_data holds its previous value.
  - The owner's rsp_valid is set and the FSM returns to IDLE.
- rsp_valid clears after one cycle. rsp_data registers hold their value until the next read by the same owner.
- In IDLE, mem_we=0 and mem_addr, mem_mode, and mem_wdata are 0.
- Grants are never asserted in BUSY. Requests arriving in BUSY wait.

## Timing
- Reset (asynchronous): state IDLE; all gnt, rsp_valid, and mem_* outputs 0; rsp_data 0; counter and starvation count 0.
- If reset is asserted mid-BUSY, the access is dropped: no write and no response. Requesters must re-issue.
- Grant in cycle T, BUSY in T+1..T+ACCESS_CYCLES, rsp_valid high in T+ACCESS_CYCLES+1.
- The response cycle is an IDLE cycle, so a new grant may occur in it. Peak throughput is one access per ACCESS_CYCLES+1 cycles.
- A store's write commits at the posedge ending cycle T+ACCESS_CYCLES.
- A request dropped before grant is legal. Request fields must be stable only in the grant cycle.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments in each IDLE cycle where if_req and ls_req are both high and LSU wins.
  - When the counter equals STARVE_LIMIT, the next contested IDLE decision grants fetch.
  - The counter clears on every fetch grant.
- MEM_ARB_STARVE_GUARD_EN undefined: strict LSU priority; the counter logic is absent.

## Test plan
- Single load: ls_req, ls_we=0, addr 0x10, mode 3'b011, memory word 0x1122334455667788 → ls_gnt in T, mem_we never high, ls_rsp_valid in T+3, ls_rsp_data=0x1122334455667788.
- Single store: ls_we=1, addr 0x20, mode 3'b010, wdata 0xDEADBEEF → mem_we high only in T+2, ls_rsp_valid in T+3, and a later load of 0x20 returns 0xFFFFFFFFDEADBEEF.
- Fetch: if_req, addr 0x4 → mem_mode=3'b110 during BUSY, if_rsp_valid in T+3, ls outputs stay 0.
- Contention, guard undefined: both requests held continuously → ls_gnt every 3 cycles, if_gnt never asserted.
- Contention, guard defined with STARVE_LIMIT=4: both requests held → four LSU grants, then one fetch grant, repeating.
- Reset mid-store: rst_n low in T+1 of a store to 0x30 → all outputs 0 immediately, no rsp_valid, and memory at 0x30 is unchanged.
